// File: rtl/delay_timer_13.sv
// Loadable down-counting timer with one-shot / auto-reload modes and a done pulse.
// All state, including the outputs, is registered on the falling edge of clock.
module delay_timer_13 #(
    parameter int unsigned BIT_SZ = 13
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [BIT_SZ-1:0] load_val,
    input  logic              enable,
    input  logic              periodic,
    input  logic              abort,
    output logic [BIT_SZ-1:0] count,
    output logic              busy,
    output logic              done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [BIT_SZ-1:0] period, period_n;
    logic [BIT_SZ-1:0] count_n;
    logic              done_n;

    always_ff @(negedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            period <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            period <= period_n;
            count  <= count_n;
            busy   <= (state_n == RUN);
            done   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        period_n = period;
        count_n  = count;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (load_val != '0) begin
                        period_n = load_val;
                        count_n  = load_val;
                        state_n  = RUN;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    count_n = '0;
                    state_n = IDLE;
                end else if (enable) begin
                    // count <= 1 treated as terminal so the counter can never wrap
                    if (count <= BIT_SZ'(1)) begin
                        done_n = 1'b1;
                        if (periodic) begin
                            count_n = period;
                        end else begin
                            count_n = '0;
                            state_n = IDLE;
                        end
                    end else begin
                        count_n = count - BIT_SZ'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                count_n = '0;
            end
        endcase
    end

endmodule
